// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter sharing one memory port between fetch (A) and load/store (B)
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req_a,
   input  logic we_a,
   input  logic req_b,
   input  logic we_b,
   input  logic mem_ready,
   output logic mem_sel,
   output logic mem_valid,
   output logic mem_we,
   output logic done_a,
   output logic done_b,
   output logic busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   logic [3:0] starve_cnt;
   logic       elig_a;
   logic       elig_b;
   logic       pick_a;

   // In the done cycle the completing requester's req is stale (it drops it on seeing done).
   always_comb begin
      elig_a = req_a & ~done_a;
      elig_b = req_b & ~done_b;
      pick_a = elig_a & (~elig_b | (starve_cnt == LIMIT));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         mem_sel    <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         done_a     <= 1'b0;
         done_b     <= 1'b0;
         busy       <= 1'b0;
         starve_cnt <= '0;
      end else begin
         done_a <= 1'b0;
         done_b <= 1'b0;
         case (state)
            IDLE: begin
               if (elig_a | elig_b) begin
                  state     <= BUSY;
                  busy      <= 1'b1;
                  mem_valid <= 1'b1;
                  mem_sel   <= ~pick_a;
                  mem_we    <= pick_a ? we_a : we_b;
                  // Waiting is judged on the raw req_a, so a re-request in A's own done cycle counts.
                  if (pick_a)
                     starve_cnt <= '0;
                  else if (req_a && starve_cnt != LIMIT)
                     starve_cnt <= starve_cnt + 4'd1;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  done_a    <= ~mem_sel;
                  done_b    <= mem_sel;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0, mem_ready = 1'b0;
   logic mem_sel, mem_valid, mem_we, done_a, done_b, busy;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n), .req_a(req_a), .we_a(we_a), .req_b(req_b), .we_b(we_b),
      .mem_ready(mem_ready), .mem_sel(mem_sel), .mem_valid(mem_valid), .mem_we(mem_we),
      .done_a(done_a), .done_b(done_b), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic sel;
      logic we;
      int   len;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   lat = 1;
   bit   force_ready = 1'b0;
   int   vc = 0;
   bit   in_acc = 1'b0;
   logic cur_sel, cur_we;
   int   len, blen;
   int   a_gr, db;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic sel, input logic we, input int l);
      exp_t e;
      e.sel = sel;
      e.we  = we;
      e.len = l;
      exp_q.push_back(e);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_mem_valid"}, mem_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_mem_sel"}, mem_sel, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_done_a"}, done_a, 0);
      check({tag, "_done_b"}, done_b, 0);
   endtask

   // Requesters behave synchronously: req drops one cycle after done is seen.
   task automatic drain(input int max);
      int n;
      bit pa, pb;
      n = 0; pa = 0; pb = 0;
      while ((exp_q.size() != 0 || busy || req_a || req_b) && n < max) begin
         @(negedge clk);
         if (pa) req_a = 1'b0;
         if (pb) req_b = 1'b0;
         pa = done_a;
         pb = done_b;
         n++;
      end
      check("drain_timeout", (n >= max), 0);
   endtask

   // Memory model: completes on the lat-th cycle of mem_valid.
   always @(negedge clk) begin
      if (mem_valid) begin
         vc++;
         mem_ready = force_ready || (vc >= lat);
      end else begin
         vc = 0;
         mem_ready = force_ready;
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
         in_acc = 1'b0;
      end else begin
         if (done_a && done_b) check("done_both", 1, 0);
         if (mem_valid) begin
            if (!in_acc) begin
               in_acc  = 1'b1;
               cur_sel = mem_sel;
               cur_we  = mem_we;
               len     = 0;
               blen    = 0;
            end else begin
               check("sel_stable", mem_sel, cur_sel);
               check("we_stable", mem_we, cur_we);
            end
            len++;
            if (busy) blen++;
         end else if (done_a || done_b) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("done_side", {done_a, done_b}, e.sel ? 2'b01 : 2'b10);
               check("grant_sel", cur_sel, e.sel);
               check("grant_we", cur_we, e.we);
               check("valid_len", len, e.len);
               check("busy_len", blen, e.len);
            end
            in_acc = 1'b0;
         end else begin
            in_acc = 1'b0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      // Reset with both requesting, then B wins first; B stays stale-high in its done cycle.
      req_a = 1'b1; req_b = 1'b1; lat = 1;
      repeat (2) @(negedge clk);
      check_idle_outputs("rst");
      push(1'b1, 1'b0, 1);
      push(1'b0, 1'b0, 1);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_first_sel", mem_sel, 1);
      check("rst_first_valid", mem_valid, 1);
      drain(50);

      // Single A read, completes on third BUSY cycle.
      @(negedge clk);
      lat = 3; req_a = 1'b1;
      push(1'b0, 1'b0, 3);
      drain(50);

      // B write with immediate ready.
      @(negedge clk);
      lat = 1; req_b = 1'b1; we_b = 1'b1;
      push(1'b1, 1'b1, 1);
      drain(50);
      we_b = 1'b0;

      // mem_ready in IDLE is ignored, then a single-cycle A access.
      @(negedge clk);
      force_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_ready_valid", mem_valid, 0);
      check("idle_ready_busy", busy, 0);
      req_a = 1'b1;
      push(1'b0, 1'b0, 1);
      drain(50);
      force_ready = 1'b0;

      // Starvation: A waits on every B grant, so pattern is B,B,B,B,A twice.
      @(negedge clk);
      lat = 1;
      for (int i = 0; i < 2; i++) begin
         repeat (4) push(1'b1, 1'b0, 1);
         push(1'b0, 1'b0, 1);
      end
      req_a = 1'b1; req_b = 1'b1; a_gr = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (mem_valid && !mem_sel) a_gr++;
         if (a_gr >= 2) req_b = 1'b0;
         if (a_gr >= 2 && done_a) begin
            req_a = 1'b0;
            break;
         end
         req_a = !done_b;
      end
      check("starve_loop_done", a_gr, 2);
      drain(50);

      // A drops req mid-access; done_a still pulses once.
      @(negedge clk);
      lat = 3; req_a = 1'b1;
      push(1'b0, 1'b0, 3);
      for (int n = 0; n < 20 && !mem_valid; n++) @(negedge clk);
      check("drop_granted", mem_valid, 1);
      req_a = 1'b0;
      drain(50);
      check("drop_idle_busy", busy, 0);

      // Raise starve count to the limit, reset mid-BUSY, count must be cleared.
      @(negedge clk);
      lat = 1; db = 0;
      repeat (3) push(1'b1, 1'b0, 1);
      req_a = 1'b1; req_b = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (busy && db == 3) break;
         if (done_b) db++;
         if (db == 3) lat = 100;
         req_a = !done_b;
      end
      check("pre_rst_busy", busy, 1);
      check("pre_rst_sel", mem_sel, 1);
      req_a = 1'b1;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_idle_outputs("async_rst");
      @(negedge clk);
      check_idle_outputs("async_rst_hold");
      lat = 1;
      push(1'b1, 1'b0, 1);
      push(1'b0, 1'b0, 1);
      reset_n = 1'b1;
      drain(50);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
